// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the two requester ports, their read-response ports and the
// unified-memory general port into one interface.
//   slave  : the arbiter side (consumes requests and mem_dout, drives
//            ready, responses and the memory command).
//   master : the environment side (requesters plus memory).
// Signals:
//   reqN_valid/ready, reqN_we[3:0], reqN_addr, reqN_wdata, req1_lock
//   rspN_valid, rspN_rdata
//   mem_en, mem_we[3:0], mem_addr, mem_din, mem_dout
interface mem_port_arbiter_if #(
    parameter int WORD_WIDTH_IN_BIT = 32
);
    logic                         req0_valid;
    logic                         req0_ready;
    logic [3:0]                   req0_we;
    logic [WORD_WIDTH_IN_BIT-1:0] req0_addr;
    logic [WORD_WIDTH_IN_BIT-1:0] req0_wdata;

    logic                         req1_valid;
    logic                         req1_ready;
    logic [3:0]                   req1_we;
    logic [WORD_WIDTH_IN_BIT-1:0] req1_addr;
    logic [WORD_WIDTH_IN_BIT-1:0] req1_wdata;
    logic                         req1_lock;

    logic                         rsp0_valid;
    logic [WORD_WIDTH_IN_BIT-1:0] rsp0_rdata;
    logic                         rsp1_valid;
    logic [WORD_WIDTH_IN_BIT-1:0] rsp1_rdata;

    logic                         mem_en;
    logic [3:0]                   mem_we;
    logic [WORD_WIDTH_IN_BIT-1:0] mem_addr;
    logic [WORD_WIDTH_IN_BIT-1:0] mem_din;
    logic [WORD_WIDTH_IN_BIT-1:0] mem_dout;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata, req1_lock,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata, req1_lock,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Two-requester arbiter in front of the unified memory general port
// (synchronous memory, 1-cycle read latency).
//   Requester 0 : core LSU.
//   Requester 1 : loader/debug; may lock the port across back-to-back
//                 requests with req1_lock.
// Policy in ARB with both requesters valid:
//   default                       : fixed priority to requester 0, with
//                                   starvation relief for requester 1 after
//                                   STARVE_LIMIT consecutive denied cycles.
//   `define MEM_ARB_ROUND_ROBIN_EN : grant the requester opposite to the
//                                   last grant (starvation relief still wins).
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : mem_port_arbiter_if.slave (requests, responses, memory port)
module mem_port_arbiter #(
    parameter int WORD_WIDTH_IN_BIT = 32,
    parameter int STARVE_LIMIT      = 8
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic                         last_grant_q, last_grant_d;
    logic [CNT_W-1:0]             starve_cnt_q, starve_cnt_d;
    logic                         rd_pend0_q, rd_pend1_q;
    logic [WORD_WIDTH_IN_BIT-1:0] rdata0_q, rdata1_q;
    logic                         grant0, grant1;
    logic                         starved;

    assign starved = bus.req1_valid && (starve_cnt_q == LIMIT);

    // Grant selection, next state, bookkeeping
    always_comb begin
        grant0       = 1'b0;
        grant1       = 1'b0;
        state_d      = state_q;
        last_grant_d = last_grant_q;
        starve_cnt_d = starve_cnt_q;

        case (state_q)
            ARB: begin
                if (starved) begin
                    grant1 = 1'b1;
                end else if (bus.req0_valid && bus.req1_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (last_grant_q) grant0 = 1'b1;
                    else              grant1 = 1'b1;
`else
                    grant0 = 1'b1;
`endif
                end else begin
                    grant0 = bus.req0_valid;
                    grant1 = bus.req1_valid;
                end
                if (grant1 && bus.req1_lock) state_d = LOCK1;
            end
            LOCK1: begin
                // Requester 0 is shut out for the whole lock, even while
                // requester 1 is idle between its requests.
                grant1 = bus.req1_valid;
                if (!bus.req1_lock) state_d = ARB;
            end
            default: state_d = ARB;
        endcase

        // Nothing is accepted while reset is held.
        if (reset) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end

        if (grant0) last_grant_d = 1'b0;
        if (grant1) last_grant_d = 1'b1;

        // Counts denied cycles only; a dropped or served request clears it.
        if (bus.req1_valid && !grant1)
            starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 1'b1;
        else
            starve_cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB;
            last_grant_q <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Memory command: the granted request goes straight to the port.
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.mem_en     = grant0 | grant1;
    assign bus.mem_we     = grant1 ? bus.req1_we : (grant0 ? bus.req0_we : 4'b0000);
    assign bus.mem_addr   = grant1 ? bus.req1_addr  : bus.req0_addr;
    assign bus.mem_din    = grant1 ? bus.req1_wdata : bus.req0_wdata;

    // Read tracking: a pending bit per requester marks the cycle mem_dout
    // belongs to it. The held copy keeps rdata stable once valid drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend0_q <= 1'b0;
            rd_pend1_q <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            rd_pend0_q <= grant0 && (bus.req0_we == 4'b0000);
            rd_pend1_q <= grant1 && (bus.req1_we == 4'b0000);
            if (rd_pend0_q) rdata0_q <= bus.mem_dout;
            if (rd_pend1_q) rdata1_q <= bus.mem_dout;
        end
    end

    assign bus.rsp0_valid = rd_pend0_q;
    assign bus.rsp1_valid = rd_pend1_q;
    assign bus.rsp0_rdata = rd_pend0_q ? bus.mem_dout : rdata0_q;
    assign bus.rsp1_rdata = rd_pend1_q ? bus.mem_dout : rdata1_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int W   = 32;
    localparam int LIM = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WORD_WIDTH_IN_BIT(W)) bus ();

    mem_port_arbiter #(.WORD_WIDTH_IN_BIT(W), .STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural memory: 256 words, reloaded while reset is sampled high.
    logic [W-1:0] mem [0:255];

    function automatic logic [W-1:0] init_word(int i);
        if (i == 32'h40) return 32'hDEADBEEF;
        return 32'hA5000000 | (i * 32'h00010101);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] = init_word(i);
            bus.mem_dout <= '0;
        end else if (bus.mem_en) begin
            bus.mem_dout <= mem[bus.mem_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) mem[bus.mem_addr[9:2]][8*b +: 8] = bus.mem_din[8*b +: 8];
        end
    end

    // Reference model state (arbitration rules written from the policy text)
    logic         m_lock, m_last;
    int           m_starve;
    logic         m_pend0, m_pend1;
    logic [W-1:0] m_exp0, m_exp1, m_hold0, m_hold1;

    task automatic drive0(input logic v, input logic [3:0] we, input logic [W-1:0] a, input logic [W-1:0] d);
        bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic [3:0] we, input logic [W-1:0] a, input logic [W-1:0] d, input logic lk);
        bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_lock = lk;
    endtask

    task automatic idle();
        drive0(1'b0, 4'h0, '0, '0);
        drive1(1'b0, 4'h0, '0, '0, 1'b0);
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        m_lock = 1'b0; m_last = 1'b0; m_starve = 0;
        m_pend0 = 1'b0; m_pend1 = 1'b0;
        m_exp0 = '0; m_exp1 = '0; m_hold0 = '0; m_hold1 = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive0(1'b1, 4'h0, 32'h10, '0);
        drive1(1'b1, 4'hF, 32'h20, 32'h1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0: got %b expected 0", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1: got %b expected 0", bus.req1_ready); end
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b expected 0", bus.mem_en); end
        checks++; if (bus.mem_we !== 4'h0) begin errors++; $display("FAIL rst_mem_we: got %h expected 0", bus.mem_we); end
        checks++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 00", {bus.rsp0_valid, bus.rsp1_valid}); end
        checks++; if (bus.rsp0_rdata !== '0 || bus.rsp1_rdata !== '0) begin errors++; $display("FAIL rst_rdata: got %h/%h expected 0/0", bus.rsp0_rdata, bus.rsp1_rdata); end
        idle();
    endtask

    task automatic test_read_rsp();
        do_reset();
        drive0(1'b1, 4'h0, 32'h100, '0);
        @(negedge clk);
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL rd_ready0: got %b expected 1", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL rd_ready1: got %b expected 0", bus.req1_ready); end
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 4'h0) begin errors++; $display("FAIL rd_mem_cmd: got en=%b we=%h expected en=1 we=0", bus.mem_en, bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL rd_mem_addr: got %h expected 00000100", bus.mem_addr); end
        nxt(); idle();
        @(negedge clk);
        checks++; if (bus.rsp0_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp0_valid: got %b expected 1", bus.rsp0_valid); end
        checks++; if (bus.rsp0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rsp0_rdata: got %h expected deadbeef", bus.rsp0_rdata); end
        checks++; if (bus.rsp1_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp1_valid: got %b expected 0", bus.rsp1_valid); end
        nxt();
        @(negedge clk);
        checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp0_drop: got %b expected 0", bus.rsp0_valid); end
        checks++; if (bus.rsp0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rsp0_hold: got %h expected deadbeef", bus.rsp0_rdata); end
    endtask

    task automatic test_both_valid();
        logic exp1;
        do_reset();
        drive0(1'b1, 4'h0, 32'h0, '0);
        drive1(1'b1, 4'h0, 32'h4, '0, 1'b0);
        for (int k = 0; k < 3 * (LIM + 1); k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp1 = (k % 2 == 0);
`else
            exp1 = (k % (LIM + 1) == LIM);
`endif
            @(negedge clk);
            checks++;
            if ({bus.req0_ready, bus.req1_ready} !== {~exp1, exp1}) begin
                errors++;
                $display("FAIL both_grant[%0d]: got r0r1=%b%b expected %b%b", k, bus.req0_ready, bus.req1_ready, ~exp1, exp1);
            end
            nxt();
        end
        idle();
    endtask

    task automatic test_lock();
        do_reset();
        drive1(1'b1, 4'hF, 32'h40, 32'h11111111, 1'b1);
        @(negedge clk);
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL lock_first: got %b expected 1", bus.req1_ready); end
        for (int k = 1; k < 3; k++) begin
            nxt();
            drive0(1'b1, 4'h0, 32'h80, '0);
            drive1(1'b1, 4'hF, 32'h40 + 4 * k, 32'h11111111 * k, 1'b1);
            @(negedge clk);
            checks++;
            if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
                errors++; $display("FAIL lock_hold[%0d]: got r0r1=%b%b expected 01", k, bus.req0_ready, bus.req1_ready);
            end
            checks++; if (bus.mem_we !== 4'hF) begin errors++; $display("FAIL lock_we[%0d]: got %h expected f", k, bus.mem_we); end
        end
        nxt();
        drive1(1'b0, 4'h0, '0, '0, 1'b0);
        @(negedge clk);
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL lock_drop: got r0r1=%b%b expected 00", bus.req0_ready, bus.req1_ready); end
        nxt();
        @(negedge clk);
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL lock_release: got %b expected 1", bus.req0_ready); end
        nxt(); idle();
    endtask

    task automatic test_strobe_write();
        do_reset();
        drive1(1'b1, 4'b0100, 32'h202, 32'h00CC0000, 1'b0);
        @(negedge clk);
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL wr_ready1: got %b expected 1", bus.req1_ready); end
        checks++; if (bus.mem_we !== 4'b0100) begin errors++; $display("FAIL wr_mem_we: got %b expected 0100", bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'h202) begin errors++; $display("FAIL wr_mem_addr: got %h expected 00000202", bus.mem_addr); end
        checks++; if (bus.mem_din !== 32'h00CC0000) begin errors++; $display("FAIL wr_mem_din: got %h expected 00cc0000", bus.mem_din); end
        nxt(); idle();
        @(negedge clk);
        checks++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin errors++; $display("FAIL wr_no_rsp: got %b expected 00", {bus.rsp0_valid, bus.rsp1_valid}); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] exp;
        do_reset();
        drive0(1'b1, 4'h0, 32'h100, '0);
        @(negedge clk);
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL mid_accept: got %b expected 1", bus.req0_ready); end
        @(posedge clk); #1 idle();
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_kill: got %b expected 0", bus.rsp0_valid); end
        checks++; if (bus.rsp0_rdata !== '0) begin errors++; $display("FAIL mid_rdata_clr: got %h expected 0", bus.rsp0_rdata); end
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL mid_no_late_rsp: got %b expected 0", bus.rsp0_valid); end
        nxt();
        drive0(1'b1, 4'h0, 32'h104, '0);
        @(negedge clk);
        exp = mem[8'h41];
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL mid_next_accept: got %b expected 1", bus.req0_ready); end
        nxt(); idle();
        @(negedge clk);
        checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_rdata !== exp) begin errors++; $display("FAIL mid_next_rsp: got v=%b d=%h expected v=1 d=%h", bus.rsp0_valid, bus.rsp0_rdata, exp); end
    endtask

    task automatic test_random();
        logic v0, v1, lk, e0, e1;
        logic [3:0] we0, we1, ewe;
        logic [W-1:0] a0, a1, d0, d1, ea, ed;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            v0 = ($urandom_range(0, 9) < 7); v1 = ($urandom_range(0, 9) < 6);
            lk = $urandom_range(0, 1);
            we0 = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            we1 = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            a0 = W'($urandom_range(0, 1023)); a1 = W'($urandom_range(0, 1023));
            d0 = $urandom; d1 = $urandom;
            drive0(v0, we0, a0, d0);
            drive1(v1, we1, a1, d1, lk);
            @(negedge clk);
            checks++; if (bus.rsp0_valid !== m_pend0) begin errors++; $display("FAIL rnd_rsp0_valid[%0d]: got %b expected %b", c, bus.rsp0_valid, m_pend0); end
            checks++; if (bus.rsp0_rdata !== (m_pend0 ? m_exp0 : m_hold0)) begin errors++; $display("FAIL rnd_rsp0_rdata[%0d]: got %h expected %h", c, bus.rsp0_rdata, m_pend0 ? m_exp0 : m_hold0); end
            checks++; if (bus.rsp1_valid !== m_pend1) begin errors++; $display("FAIL rnd_rsp1_valid[%0d]: got %b expected %b", c, bus.rsp1_valid, m_pend1); end
            checks++; if (bus.rsp1_rdata !== (m_pend1 ? m_exp1 : m_hold1)) begin errors++; $display("FAIL rnd_rsp1_rdata[%0d]: got %h expected %h", c, bus.rsp1_rdata, m_pend1 ? m_exp1 : m_hold1); end
            if (m_pend0) m_hold0 = m_exp0;
            if (m_pend1) m_hold1 = m_exp1;

            e0 = 1'b0; e1 = 1'b0;
            if (m_lock) e1 = v1;
            else if (v1 && m_starve == LIM) e1 = 1'b1;
            else if (v0 && v1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                e1 = (m_last == 1'b0);
`else
                e1 = 1'b0;
`endif
                e0 = !e1;
            end else begin
                e0 = v0; e1 = v1;
            end

            checks++; if ({bus.req0_ready, bus.req1_ready} !== {e0, e1}) begin errors++; $display("FAIL rnd_grant[%0d]: got r0r1=%b%b expected %b%b", c, bus.req0_ready, bus.req1_ready, e0, e1); end
            checks++; if (bus.mem_en !== (e0 | e1)) begin errors++; $display("FAIL rnd_mem_en[%0d]: got %b expected %b", c, bus.mem_en, e0 | e1); end
            if (e0 || e1) begin
                ewe = e1 ? we1 : we0; ea = e1 ? a1 : a0; ed = e1 ? d1 : d0;
                checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_din} !== {ewe, ea, ed}) begin errors++; $display("FAIL rnd_mem_cmd[%0d]: got we=%h a=%h d=%h expected we=%h a=%h d=%h", c, bus.mem_we, bus.mem_addr, bus.mem_din, ewe, ea, ed); end
            end else begin
                checks++; if (bus.mem_we !== 4'h0) begin errors++; $display("FAIL rnd_mem_we_idle[%0d]: got %h expected 0", c, bus.mem_we); end
            end

            m_pend0 = e0 && (we0 == 4'h0); m_exp0 = mem[a0[9:2]];
            m_pend1 = e1 && (we1 == 4'h0); m_exp1 = mem[a1[9:2]];
            if (e0) m_last = 1'b0;
            if (e1) m_last = 1'b1;
            m_starve = (v1 && !e1) ? ((m_starve == LIM) ? LIM : m_starve + 1) : 0;
            m_lock = m_lock ? lk : (e1 && lk);
            nxt();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_read_rsp();
        test_both_valid();
        test_lock();
        test_strobe_write();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter WORD_WIDTH_IN_BIT, default 32: data and address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: consecutive denied cycles before requester 1 is forced through.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  request pending (0 = core LSU, 1 = loader/debug).
REQ-006 SHALL have ports req0_ready/req1_ready  output  1  request accepted this cycle.
REQ-007 SHALL have ports req0_we/req1_we  input  4  byte write strobes, 0 = read.
REQ-008 SHALL have ports req0_addr/req1_addr  input  WORD_WIDTH_IN_BIT  byte address.
REQ-009 SHALL have ports req0_wdata/req1_wdata  input  WORD_WIDTH_IN_BIT  write data, already lane-aligned.
REQ-010 SHALL have port req1_lock  input  1  loader holds grant across back-to-back requests.
REQ-011 SHALL have ports rsp0_valid/rsp1_valid  output  1  read data valid.
REQ-012 SHALL have ports rsp0_rdata/rsp1_rdata  output  WORD_WIDTH_IN_BIT  read data.
REQ-013 SHALL have ports mem_en  output  1, mem_we  output  4, mem_addr/mem_din  output  WORD_WIDTH_IN_BIT, mem_dout  input  WORD_WIDTH_IN_BIT  to the unified memory general port (synchronous, 1-cycle read latency).

Function
REQ-014 SHALL grant at most one requester per cycle; reqN_ready = grant to N, combinational from valids and state.
REQ-015 SHALL drive the granted request onto mem_en=1, mem_we, mem_addr, mem_din in the same cycle; with no grant mem_en=0, mem_we=0.
REQ-016 SHALL assert rspN_valid exactly one cycle after an accepted read (we==0) by N, with rspN_rdata=mem_dout; writes produce no response.
REQ-017 SHALL hold rspN_rdata at last value when rspN_valid=0; the non-target rsp_valid stays 0.
REQ-018 SHALL implement FSM {ARB, LOCK1}: ARB->LOCK1 when req1 accepted with req1_lock=1; LOCK1->ARB when req1_lock=0 at a cycle edge.
REQ-019 SHALL in LOCK1 grant only requester 1 (when req1_valid); requester 0 ready=0 even if requester 1 idle.
REQ-020 SHALL in ARB with single valid requester grant it immediately.
REQ-021 SHALL keep starve_cnt: increment (saturating at STARVE_LIMIT) each cycle req1_valid=1 and not granted; clear on req1 grant or req1_valid=0.
REQ-022 SHALL in ARB, when starve_cnt==STARVE_LIMIT and req1_valid, grant requester 1 regardless of policy.
REQ-023 SHALL keep last_grant register (0/1) updated on every accepted request.
REQ-024 SHALL tolerate a requester dropping valid without acceptance (no state change beyond starve_cnt clear).

Reset
REQ-025 SHALL on reset asynchronously set: state=ARB, last_grant=0, starve_cnt=0, rsp0_valid=rsp1_valid=0, rsp0_rdata=rsp1_rdata=0.
REQ-026 SHALL force req0_ready=req1_ready=0 and mem_en=0, mem_we=0 while reset is high; a read in flight at reset produces no response.

Configuration
REQ-027 SHALL support macro MEM_ARB_ROUND_ROBIN_EN: defined -> in ARB with both valid, grant requester opposite to last_grant (subject to REQ-022).
REQ-028 SHALL without MEM_ARB_ROUND_ROBIN_EN, in ARB with both valid, grant requester 0 (fixed priority), starvation relief per REQ-022 only.

Verification
REQ-029 SHALL cover: req0 read addr 0x100, mem_dout=0xDEADBEEF next cycle -> req0_ready same cycle, rsp0_valid=1 with 0xDEADBEEF one cycle later, rsp1_valid=0.
REQ-030 SHALL cover: both valid continuously, macro undefined, STARVE_LIMIT=8 -> 8 grants to 0, then one grant to 1, repeating.
REQ-031 SHALL cover: both valid, macro defined -> grants alternate 0,1,0,1 starting with 1 after reset (last_grant=0).
REQ-032 SHALL cover: req1 write we=4'b1111 with req1_lock=1 for 3 requests while req0_valid=1 -> req0_ready=0 until cycle after req1_lock drops.
REQ-033 SHALL cover: reset asserted mid-cycle after accepted read -> rsp valids 0 immediately, no response after release, next request served normally.
REQ-034 SHALL cover: req1 write byte strobe 4'b0100 addr 0x202 -> mem_we=4'b0100, mem_addr=0x202, no rsp1_valid.
